ibex_scramble_key_arbiter: RTL and testbench
============================================

Name: ibex_scramble_key_arbiter

Overview:
- Shares one OTP scramble key/nonce port between NumReq memory requesters (ICache, RAMs, ...).
- Each requester raises a request for a fresh key; the block round-robin arbitrates, runs the request/ack handshake to OTP, broadcasts the returned key/nonce and pulses the served requester.
- Tracks key validity per requester.
- Bounds each OTP transaction with a timeout and retries after it.

Parameters:
- NumReq, 2, number of requesters (2..8).
- TimeoutCycles, 1024, max cycles waiting for otp_ack_i before abandoning the transaction (>=2).
- RndCnstIbexKey, RndCnstIbexKeyDefault, reset value of key_o (SCRAMBLE_KEY_W bits).
- RndCnstIbexNonce, RndCnstIbexNonceDefault, reset value of nonce_o (SCRAMBLE_NONCE_W bits).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumReq  per-requester "need new key" request; level, sampled every cycle.
- key_valid_o  out  NumReq  per-requester key currently valid.
- ack_o  out  NumReq  one-cycle pulse: key_o/nonce_o now hold this requester's key.
- key_o  out  SCRAMBLE_KEY_W  last key returned by OTP.
- nonce_o  out  SCRAMBLE_NONCE_W  last nonce returned by OTP.
- otp_req_o  out  1  request to OTP.
- otp_ack_i  in  1  OTP response valid, single cycle.
- otp_key_i  in  SCRAMBLE_KEY_W  key from OTP, valid with otp_ack_i.
- otp_nonce_i  in  SCRAMBLE_NONCE_W  nonce from OTP, valid with otp_ack_i.
- timeout_o  out  1  one-cycle pulse when a transaction times out.
- busy_o  out  1  FSM not in Idle.

Behaviour:
- Reset values:
  - key_o=RndCnstIbexKey, nonce_o=RndCnstIbexNonce.
  - key_valid_o=all 1, ack_o=0, otp_req_o=0, timeout_o=0, busy_o=0.
  - pending_q=0, rr pointer=0, FSM=Idle, timer=0.
- Pending: pending_q[i] is set at the edge where req_i[i]=1 and cleared only on an ack to i.
  - key_valid_o[i] falls at the same edge pending_q[i] sets.
  - If req_i[i]=1 in the cycle ack for i is taken: pending_q[i] stays set, key_valid_o[i] stays 0, and ack_o[i] still pulses.
- FSM states:
  - Idle: if pending_q!=0, grant the first set bit at or after the rr pointer (wrapping NumReq-1 -> 0), register gnt_idx, go to Req. Else stay.
  - Req: otp_req_o=1; timer increments each cycle.
    - On otp_ack_i=1: at the next edge load key_o/nonce_o from otp_key_i/otp_nonce_i, clear pending_q[gnt_idx] (subject to the rule above), set key_valid_o[gnt_idx], set rr pointer=(gnt_idx+1) mod NumReq, go to Idle.
    - ack_o[gnt_idx] is a registered pulse in that following cycle.
    - If timer reaches TimeoutCycles-1 without ack: go to Idle with timeout_o pulsed one cycle. The pending bit is kept and the pointer advances past gnt_idx, so the transaction is retried fairly.
- Latency: req_i high in cycle 0 -> pending cycle 1 -> otp_req_o high cycle 2. otp_ack_i in cycle k -> ack_o/key_o/key_valid_o updated in cycle k+1, Idle in k+1, next otp_req_o no earlier than k+2.
- otp_req_o deasserts in the cycle after ack. A late ack arriving in Idle is ignored (no key update).
- Simultaneous timeout and ack on the same cycle: ack wins, no timeout_o.
- key_o/nonce_o change only on accepted acks. Non-granted requesters must ignore them when their ack_o=0.
- Async reset mid-transaction returns everything to reset values immediately; otp_req_o drops asynchronously.
- busy_o=1 in Req.

Test Plan:
1. Reset, no requests -> key_valid_o=2'b11, key_o=RndCnstIbexKey, otp_req_o=0 for 20 cycles.
2. Pulse req_i=2'b01 cycle 0; OTP acks cycle 5 with key=K1 -> otp_req_o high cycles 2-5, ack_o=2'b01 and key_o=K1 in cycle 6, key_valid_o=2'b11 from cycle 6.
3. req_i=2'b11 same cycle, OTP acks 3 cycles after each request -> requester 0 served first, then 1. Repeat with pointer=1 -> requester 1 first. No requester waits more than NumReq grants.
4. TimeoutCycles=8, req_i[1] pulse, OTP never acks -> otp_req_o high 8 cycles, timeout_o pulse, otp_req_o 0 for one cycle, then re-requested; key_valid_o[1] stays 0.
5. req_i[0] re-asserted in the ack cycle for 0 -> ack_o[0] pulses, key_valid_o[0] stays 0, second OTP transaction starts.
6. Assert rst_ni=0 while otp_req_o=1 -> otp_req_o=0 immediately, all outputs at reset values, late otp_ack_i after reset ignored.

Source files
------------

// File: rtl/ibex_scramble_key_arbiter.sv
// Shares one OTP scramble key/nonce port between NumReq requesters: round-robin grant,
// bounded OTP request/ack handshake, key/nonce broadcast and per-requester key validity.
module ibex_scramble_key_arbiter #(
   parameter int unsigned NumReq           = 2,
   parameter int unsigned TimeoutCycles    = 1024,
   parameter int unsigned SCRAMBLE_KEY_W   = 128,
   parameter int unsigned SCRAMBLE_NONCE_W = 64,
   parameter logic [SCRAMBLE_KEY_W-1:0]   RndCnstIbexKey   = 128'h14e8cecae3040d5e12286bb3cc113298,
   parameter logic [SCRAMBLE_NONCE_W-1:0] RndCnstIbexNonce = 64'hf79780bc735f3843
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumReq-1:0]           req_i,
   output logic [NumReq-1:0]           key_valid_o,
   output logic [NumReq-1:0]           ack_o,
   output logic [SCRAMBLE_KEY_W-1:0]   key_o,
   output logic [SCRAMBLE_NONCE_W-1:0] nonce_o,
   output logic                        otp_req_o,
   input  logic                        otp_ack_i,
   input  logic [SCRAMBLE_KEY_W-1:0]   otp_key_i,
   input  logic [SCRAMBLE_NONCE_W-1:0] otp_nonce_i,
   output logic                        timeout_o,
   output logic                        busy_o
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned TmrW = $clog2(TimeoutCycles);

   // OTP handshake: otp_req_o stays high for the whole StReq phase; a transaction
   // completes on the single cycle where otp_ack_i is seen while in StReq.
   typedef enum logic {StIdle, StReq} state_e;

   state_e                      state_q, state_d;
   logic [NumReq-1:0]           pending_q, pending_d;
   logic [NumReq-1:0]           key_valid_q, key_valid_d;
   logic [NumReq-1:0]           ack_q, ack_d;
   logic [IdxW-1:0]             rr_q, rr_d, gnt_q, gnt_d;
   logic [IdxW-1:0]             pick_idx, cand;
   logic                        pick_found;
   logic [IdxW-1:0]             gnt_next;
   logic [TmrW-1:0]             timer_q, timer_d;
   logic                        timeout_q, timeout_d;
   logic                        ack_take;
   logic [SCRAMBLE_KEY_W-1:0]   key_q;
   logic [SCRAMBLE_NONCE_W-1:0] nonce_q;

   // First pending requester at or after the round-robin pointer, wrapping.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int unsigned off = 0; off < NumReq; off++) begin
         cand = IdxW'((32'(rr_q) + off) % NumReq);
         if (!pick_found && pending_q[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign gnt_next = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_d      = rr_q;
      timer_d   = timer_q;
      ack_d     = '0;
      timeout_d = 1'b0;
      ack_take  = 1'b0;
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (pick_found) begin
               gnt_d   = pick_idx;
               state_d = StReq;
            end
         end
         StReq: begin
            // An ack on the final timeout cycle still completes the transaction.
            if (otp_ack_i) begin
               ack_take     = 1'b1;
               ack_d[gnt_q] = 1'b1;
               rr_d         = gnt_next;
               timer_d      = '0;
               state_d      = StIdle;
            end else if (timer_q == TmrW'(TimeoutCycles - 1)) begin
               timeout_d = 1'b1;
               rr_d      = gnt_next;
               timer_d   = '0;
               state_d   = StIdle;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A request seen in the same cycle as its ack keeps the requester pending and invalid.
   assign pending_d   = (pending_q & ~ack_d) | req_i;
   assign key_valid_d = (key_valid_q & ~req_i) | (ack_d & ~req_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         key_valid_q <= '1;
         ack_q       <= '0;
         rr_q        <= '0;
         gnt_q       <= '0;
         timer_q     <= '0;
         timeout_q   <= 1'b0;
         key_q       <= RndCnstIbexKey;
         nonce_q     <= RndCnstIbexNonce;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         key_valid_q <= key_valid_d;
         ack_q       <= ack_d;
         rr_q        <= rr_d;
         gnt_q       <= gnt_d;
         timer_q     <= timer_d;
         timeout_q   <= timeout_d;
         if (ack_take) begin
            key_q   <= otp_key_i;
            nonce_q <= otp_nonce_i;
         end
      end
   end

   assign otp_req_o   = (state_q == StReq);
   assign busy_o      = (state_q != StIdle);
   assign key_valid_o = key_valid_q;
   assign ack_o       = ack_q;
   assign timeout_o   = timeout_q;
   assign key_o       = key_q;
   assign nonce_o     = nonce_q;

endmodule

// File: tb/tb_ibex_scramble_key_arbiter.sv
// Randomized bench for ibex_scramble_key_arbiter: transaction-level reference model,
// expected-ack queue drained by an independent monitor, mid-transaction reset.
module tb_ibex_scramble_key_arbiter;

   localparam int N  = 3;
   localparam int T  = 8;
   localparam int KW = 128;
   localparam int NW = 64;
   localparam int EW = N + KW + NW;
   localparam logic [KW-1:0] RST_KEY   = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [NW-1:0] RST_NONCE = 64'h5a5a_a5a5_3c3c_c3c3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]  req_i = '0;
   logic          otp_ack_i = 1'b0;
   logic [KW-1:0] otp_key_i = '0;
   logic [NW-1:0] otp_nonce_i = '0;
   logic [N-1:0]  key_valid_o, ack_o;
   logic [KW-1:0] key_o;
   logic [NW-1:0] nonce_o;
   logic          otp_req_o, timeout_o, busy_o;

   ibex_scramble_key_arbiter #(
      .NumReq(N), .TimeoutCycles(T), .SCRAMBLE_KEY_W(KW), .SCRAMBLE_NONCE_W(NW),
      .RndCnstIbexKey(RST_KEY), .RndCnstIbexNonce(RST_NONCE)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .key_valid_o(key_valid_o),
      .ack_o(ack_o), .key_o(key_o), .nonce_o(nonce_o), .otp_req_o(otp_req_o),
      .otp_ack_i(otp_ack_i), .otp_key_i(otp_key_i), .otp_nonce_i(otp_nonce_i),
      .timeout_o(timeout_o), .busy_o(busy_o)
   );

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending set, validity, rr pointer and the OTP transaction in flight.
   logic [N-1:0]  m_pend, m_valid;
   int            m_ptr, m_gnt, m_cnt, m_delay;
   bit            m_busy, m_tmo;
   logic [KW-1:0] m_key;
   logic [NW-1:0] m_nonce;

   function automatic int pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++)
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_valid = '1; m_ptr = 0; m_gnt = 0; m_cnt = 0; m_delay = 0;
      m_busy = 1'b0; m_tmo = 1'b0; m_key = RST_KEY; m_nonce = RST_NONCE;
   endtask

   // One cycle: observe and compare, drive next inputs, advance the model.
   // Returns did_rst=1 if it applied an asynchronous reset instead of normal stimulus.
   task automatic step(input int dens, input bit rst_when_busy, output bit did_rst);
      logic [N-1:0]  rq, clr, n_pend, n_valid;
      logic          ak;
      logic [KW-1:0] k;
      logic [NW-1:0] nn;
      did_rst = 1'b0;
      @(negedge clk);
      chk("otp_req", 256'(otp_req_o), 256'(m_busy));
      chk("busy", 256'(busy_o), 256'(m_busy));
      chk("key_valid", 256'(key_valid_o), 256'(m_valid));
      chk("timeout", 256'(timeout_o), 256'(m_tmo));
      chk("key", 256'(key_o), 256'(m_key));
      chk("nonce", 256'(nonce_o), 256'(m_nonce));
      if (rst_when_busy && m_busy) begin
         req_i = '0; otp_ack_i = 1'b0;
         #1 rst_ni = 1'b0;
         #1;
         chk("rst_otp_req", 256'(otp_req_o), 256'(0));
         chk("rst_busy", 256'(busy_o), 256'(0));
         chk("rst_key", 256'(key_o), 256'(RST_KEY));
         chk("rst_nonce", 256'(nonce_o), 256'(RST_NONCE));
         chk("rst_key_valid", 256'(key_valid_o), 256'({N{1'b1}}));
         chk("rst_ack", 256'(ack_o), 256'(0));
         otp_ack_i = 1'b1;
         otp_key_i = {$urandom(), $urandom(), $urandom(), $urandom()};
         otp_nonce_i = {$urandom(), $urandom()};
         model_reset();
         did_rst = 1'b1;
         return;
      end
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 99) < dens);
      k  = {$urandom(), $urandom(), $urandom(), $urandom()};
      nn = {$urandom(), $urandom()};
      ak = 1'b0;
      if (m_busy && m_cnt == m_delay) ak = 1'b1;
      else if (!m_busy && $urandom_range(0, 19) == 0) ak = 1'b1;
      req_i = rq; otp_ack_i = ak; otp_key_i = k; otp_nonce_i = nn;
      clr = '0;
      if (m_busy && ak) begin
         clr[m_gnt] = 1'b1;
         exp_q.push_back({clr, k, nn});
      end
      n_pend  = (m_pend & ~clr) | rq;
      n_valid = (m_valid & ~rq) | (clr & ~rq);
      m_tmo = 1'b0;
      if (m_busy) begin
         if (ak) begin
            m_key = k; m_nonce = nn; m_ptr = (m_gnt + 1) % N; m_busy = 1'b0;
         end else if (m_cnt == T - 1) begin
            m_tmo = 1'b1; m_ptr = (m_gnt + 1) % N; m_busy = 1'b0;
         end else begin
            m_cnt++;
         end
      end else if (m_pend != '0) begin
         m_gnt = pick(m_pend, m_ptr); m_busy = 1'b1; m_cnt = 0;
         m_delay = $urandom_range(0, T + 1);
      end
      m_pend = n_pend; m_valid = n_valid;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_o", 256'(ack_o), 256'(e[EW-1 -: N]));
            chk("ack_key", 256'(key_o), 256'(e[NW +: KW]));
            chk("ack_nonce", 256'(nonce_o), 256'(e[NW-1:0]));
         end else if (ack_o != '0) begin
            chk("spurious_ack", 256'(ack_o), 256'(0));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bit r;
      int guard;
      model_reset();
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      repeat (20) step(0, 1'b0, r);
      repeat (600) step(30, 1'b0, r);
      repeat (300) step(5, 1'b0, r);
      // Reset while OTP is being requested; a late ack during/after reset must be ignored.
      guard = 0;
      r = 1'b0;
      while (!r && guard < 200) begin
         step(40, 1'b1, r);
         guard++;
      end
      if (!r) chk("reach_busy_for_reset", 256'(0), 256'(1));
      else begin
         @(negedge clk);
         rst_ni = 1'b1;
      end
      repeat (600) step(80, 1'b0, r);
      repeat (400) step(15, 1'b0, r);
      guard = 0;
      while ((m_busy || m_pend != '0) && guard < 500) begin
         step(0, 1'b0, r);
         guard++;
      end
      if (m_busy || m_pend != '0) chk("drain", 256'(m_pend), 256'(0));
      repeat (4) step(0, 1'b0, r);
      chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1);
   end

endmodule
